prog_loader: RTL



---
 rtl/prog_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over valid/ready, writes it into program memory,
// zero-fills the tail and releases the CPU from reset only once the checksum matches.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 32,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  input  logic              reload_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   len_o
);
  typedef enum logic [2:0] {S_HDR, S_LEN, S_DATA, S_CSUM, S_FILL, S_RUN, S_ERR} state_t;
  localparam logic [ADDR_W:0] ONE = 1;
  state_t r_state, w_next;
  logic [ADDR_W:0] r_cnt, r_len;
  logic [7:0] r_sum, r_data;
  logic [ADDR_W-1:0] r_addr;
  logic r_we, r_cpu_rst, r_done, r_err;
  logic w_acc, w_len_ok, w_last, w_sum_ok, w_short, w_fill_end;
  assign w_acc = s_valid_i & s_ready_o;
  assign w_len_ok = (s_data_i != 8'd0) && (s_data_i <= 8'(DEPTH));
  assign w_last = r_cnt == r_len - ONE;
  assign w_sum_ok = s_data_i == r_sum;
  assign w_short = r_len < (ADDR_W+1)'(DEPTH);
  assign w_fill_end = r_addr == ADDR_W'(DEPTH - 1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= S_HDR;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR:  if (w_acc && s_data_i == SYNC) w_next = S_LEN;
      S_LEN:  if (w_acc) w_next = w_len_ok ? S_DATA : S_ERR;
      S_DATA: if (w_acc && w_last) w_next = S_CSUM;
      S_CSUM: if (w_acc) w_next = !w_sum_ok ? S_ERR : w_short ? S_FILL : S_RUN;
      S_FILL: if (w_fill_end) w_next = S_RUN;
      default: ;
    endcase
    if (reload_i) w_next = S_HDR;
  end
  always_comb s_ready_o = r_state inside {S_HDR, S_LEN, S_DATA, S_CSUM};
  // The first fill write is issued on the checksum accept so FILL cycles and fill pulses coincide.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_cnt <= '0;
      r_len <= '0;
      r_sum <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cpu_rst <= 1'b1;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_cpu_rst <= w_next != S_RUN;
      r_done <= w_next == S_RUN;
      r_err <= w_next == S_ERR;
      r_we <= 1'b0;
      if (reload_i) begin
        r_cnt <= '0;
        r_len <= '0;
        r_sum <= '0;
      end else case (r_state)
        S_LEN: if (w_acc && w_len_ok) begin
          r_len <= s_data_i[ADDR_W:0];
          r_cnt <= '0;
          r_sum <= '0;
        end
        S_DATA: if (w_acc) begin
          r_sum <= r_sum + s_data_i;
          r_cnt <= r_cnt + ONE;
          r_we <= 1'b1;
          r_addr <= r_cnt[ADDR_W-1:0];
          r_data <= s_data_i;
        end
        S_CSUM: if (w_acc && w_sum_ok && w_short) begin
          r_we <= 1'b1;
          r_addr <= r_len[ADDR_W-1:0];
          r_data <= 8'd0;
        end
        S_FILL: if (!w_fill_end) begin
          r_we <= 1'b1;
          r_addr <= r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  assign mem_we_o = r_we;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_data;
  assign cpu_rst_o = r_cpu_rst;
  assign done_o = r_done;
  assign err_o = r_err;
  assign len_o = r_len;
endmodule
